// File: rtl/frame_readback_tx_if.sv
// -----------------------------------------------------------------------------
// frame_readback_tx_if
// Bundles the frame-readback transmitter's request/status handshake, the
// frame-buffer RAM read port and the UART line into one interface.
//
// Signals:
//   start    host request to send one frame
//   rd_en    RAM read enable
//   rd_addr  RAM read address (ADDR_W bits)
//   rd_data  RAM read data, valid the cycle after rd_en
//   tx       UART 8N1 serial output, idle high
//   busy     frame transfer in progress
//   done     one-cycle pulse after the last stop bit
//
// Modports:
//   master  transmitter side (drives rd_en/rd_addr/tx/busy/done)
//   slave   system side (drives start and rd_data)
// -----------------------------------------------------------------------------
interface frame_readback_tx_if #(
    parameter int ADDR_W = 14
);
    logic              start;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [7:0]        rd_data;
    logic              tx;
    logic              busy;
    logic              done;

    modport master (
        input  start,
        input  rd_data,
        output rd_en,
        output rd_addr,
        output tx,
        output busy,
        output done
    );

    modport slave (
        output start,
        output rd_data,
        input  rd_en,
        input  rd_addr,
        input  tx,
        input  busy,
        input  done
    );
endinterface

// File: rtl/frame_readback_tx.sv
// -----------------------------------------------------------------------------
// frame_readback_tx
// Reads a stored frame out of the pixel frame-buffer RAM (second synchronous
// read port, 1-cycle latency) and transmits it byte by byte as UART 8N1.
// Each byte costs one FETCH cycle, one WAIT cycle and 10 bit periods of
// BAUD_DIV clocks.
//
// Ports:
//   sclk   system clock (only clock)
//   rst_n  asynchronous active-low reset
//   bus    frame_readback_tx_if.master: start, rd_en, rd_addr, rd_data,
//          tx, busy, done
// -----------------------------------------------------------------------------
module frame_readback_tx #(
    parameter int PIX_NUM  = 10000,
    parameter int ADDR_W   = 14,
    parameter int BAUD_DIV = 5208
) (
    input  logic                 sclk,
    input  logic                 rst_n,
    frame_readback_tx_if.master  bus
);

    localparam int                BW        = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam logic [BW-1:0]     BAUD_LAST = BW'(BAUD_DIV - 1);
    localparam logic [ADDR_W-1:0] PIX_LAST  = ADDR_W'(PIX_NUM - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        WAIT  = 3'd2,
        SEND  = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic [ADDR_W-1:0] pix_cnt;
    logic [BW-1:0]     baud_cnt;
    logic [3:0]        bit_cnt;
    logic [9:0]        shift;
    logic              bit_end;
    logic              byte_end;

    assign bit_end  = (state_q == SEND) && (baud_cnt == BAUD_LAST);
    assign byte_end = bit_end && (bit_cnt == 4'd9);

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.start) state_d = FETCH;
            FETCH:   state_d = WAIT;
            WAIT:    state_d = SEND;
            SEND:    if (byte_end) state_d = (pix_cnt == PIX_LAST) ? DONE : FETCH;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State register and control counters
    always_ff @(posedge sclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            pix_cnt     <= '0;
            baud_cnt    <= '0;
            bit_cnt     <= '0;
            bus.rd_addr <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: begin
                    pix_cnt <= '0;
                    if (bus.start) bus.rd_addr <= '0;
                end
                WAIT: begin
                    baud_cnt <= '0;
                    bit_cnt  <= '0;
                end
                SEND: begin
                    if (bit_end) begin
                        baud_cnt <= '0;
                        bit_cnt  <= bit_cnt + 4'd1;
                        // Address for the next FETCH is set up here so that
                        // rd_addr is stable and equals pix_cnt during FETCH.
                        if (byte_end && (pix_cnt != PIX_LAST)) begin
                            pix_cnt     <= pix_cnt + ADDR_W'(1);
                            bus.rd_addr <= pix_cnt + ADDR_W'(1);
                        end
                    end else begin
                        baud_cnt <= baud_cnt + BW'(1);
                    end
                end
                DONE:    pix_cnt <= '0;
                default: ;
            endcase
        end
    end

    // Shift register: pure datapath, only observed while in SEND
    always_ff @(posedge sclk) begin
        if (state_q == WAIT) begin
            shift <= {1'b1, bus.rd_data, 1'b0};
        end else if (bit_end) begin
            shift <= {1'b1, shift[9:1]};
        end
    end

    // Outputs decoded from registered state only
    assign bus.rd_en = (state_q == FETCH);
    assign bus.tx    = (state_q == SEND) ? shift[0] : 1'b1;
    assign bus.busy  = (state_q != IDLE);
    assign bus.done  = (state_q == DONE);

endmodule

// File: tb/tb_frame_readback_tx.sv
// -----------------------------------------------------------------------------
// tb_frame_readback_tx
// Directed bench for frame_readback_tx with PIX_NUM=4, BAUD_DIV=4 and a RAM
// model holding 0x55, 0xA3, 0x00, 0xFF. Outputs are sampled on the falling
// edge; inputs are changed right after the falling edge.
// -----------------------------------------------------------------------------
module tb_frame_readback_tx;

    localparam int PIX_NUM  = 4;
    localparam int ADDR_W   = 2;
    localparam int BAUD_DIV = 4;
    localparam int BYTE_CYC = 2 + 10 * BAUD_DIV;   // 42
    localparam int FRAME_CYC = PIX_NUM * BYTE_CYC; // 168

    logic sclk;
    logic rst_n;
    int   tests;
    int   fails;

    logic [7:0] exp_bytes [PIX_NUM];
    logic [7:0] ram       [PIX_NUM];

    frame_readback_tx_if #(.ADDR_W(ADDR_W)) bus ();

    frame_readback_tx #(
        .PIX_NUM (PIX_NUM),
        .ADDR_W  (ADDR_W),
        .BAUD_DIV(BAUD_DIV)
    ) dut (
        .sclk (sclk),
        .rst_n(rst_n),
        .bus  (bus.master)
    );

    initial sclk = 1'b0;
    always #5 sclk = ~sclk;

    // Synchronous-read RAM model, 1-cycle latency
    always @(posedge sclk) begin
        if (bus.rd_en) bus.rd_data <= ram[bus.rd_addr];
    end

    // Walks one frame cycle by cycle; t=1 is the first cycle after the edge
    // that sampled start. Expected waveform is built from the byte table.
    task automatic check_frame(input string name, input int drop_t,
                               input int poke_t, input int abort_t);
        logic [7:0] dec;
        int   b, off, bi;
        logic exp_tx, exp_rd, exp_busy, exp_done;
        dec = 8'h00;
        for (int t = 1; t <= FRAME_CYC + 2; t++) begin
            @(negedge sclk);
            b        = (t - 1) / BYTE_CYC;
            off      = (t - 1) % BYTE_CYC;
            bi       = (off >= 2) ? (off - 2) / BAUD_DIV : -1;
            exp_busy = (t <= FRAME_CYC + 1);
            exp_done = (t == FRAME_CYC + 1);
            exp_rd   = (t <= FRAME_CYC) && (off == 0);
            exp_tx   = 1'b1;
            if (t <= FRAME_CYC && bi >= 0) begin
                if (bi == 0)      exp_tx = 1'b0;
                else if (bi == 9) exp_tx = 1'b1;
                else              exp_tx = exp_bytes[b][bi-1];
            end
            tests++;
            if (bus.tx !== exp_tx) begin
                fails++;
                $display("FAIL %s tx t=%0d: got %b want %b", name, t, bus.tx, exp_tx);
            end
            tests++;
            if (bus.rd_en !== exp_rd) begin
                fails++;
                $display("FAIL %s rd_en t=%0d: got %b want %b", name, t, bus.rd_en, exp_rd);
            end
            if (exp_rd) begin
                tests++;
                if (bus.rd_addr !== ADDR_W'(b)) begin
                    fails++;
                    $display("FAIL %s rd_addr t=%0d: got %0d want %0d", name, t, bus.rd_addr, b);
                end
            end
            tests++;
            if (bus.busy !== exp_busy || bus.done !== exp_done) begin
                fails++;
                $display("FAIL %s busy/done t=%0d: got %b/%b want %b/%b",
                         name, t, bus.busy, bus.done, exp_busy, exp_done);
            end
            // Independent serial decode: sample each data bit mid-period
            if (t <= FRAME_CYC && bi >= 1 && bi <= 8 && ((off - 2) % BAUD_DIV) == 1)
                dec[bi-1] = bus.tx;
            if (t <= FRAME_CYC && off == BYTE_CYC - 1) begin
                tests++;
                if (dec !== exp_bytes[b]) begin
                    fails++;
                    $display("FAIL %s decode byte %0d: got %h want %h", name, b, dec, exp_bytes[b]);
                end
            end
            if (t == drop_t)     bus.start = 1'b0;
            if (t == poke_t)     bus.start = 1'b1;
            if (t == poke_t + 1) bus.start = 1'b0;
            if (t == abort_t) begin
                rst_n = 1'b0;
                #1;
                tests++;
                if ({bus.tx, bus.busy, bus.rd_en, bus.done} !== 4'b1000 || bus.rd_addr !== '0) begin
                    fails++;
                    $display("FAIL %s async reset: got tx/busy/rd_en/done=%b%b%b%b addr=%0d want 1000 addr=0",
                             name, bus.tx, bus.busy, bus.rd_en, bus.done, bus.rd_addr);
                end
                return;
            end
        end
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        bus.start = 1'b0;
        repeat (3) @(negedge sclk);
        tests++;
        if ({bus.tx, bus.busy, bus.done, bus.rd_en} !== 4'b1000 || bus.rd_addr !== '0) begin
            fails++;
            $display("FAIL reset_values: got tx/busy/done/rd_en=%b%b%b%b addr=%0d want 1000 addr=0",
                     bus.tx, bus.busy, bus.done, bus.rd_en, bus.rd_addr);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_idle_line();
        for (int i = 0; i < 1000; i++) begin
            @(negedge sclk);
            tests++;
            if ({bus.tx, bus.rd_en, bus.busy, bus.done} !== 4'b1000) begin
                fails++;
                $display("FAIL idle_line cycle %0d: got tx/rd_en/busy/done=%b%b%b%b want 1000",
                         i, bus.tx, bus.rd_en, bus.busy, bus.done);
            end
        end
    endtask

    task automatic test_single_start();
        @(negedge sclk);
        bus.start = 1'b1;
        check_frame("single", 1, -1, -1);
    endtask

    task automatic test_start_while_busy();
        @(negedge sclk);
        bus.start = 1'b1;
        // t=50 lies inside the second byte (t 43..84)
        check_frame("busy_start", 1, 50, -1);
        for (int i = 0; i < 10; i++) begin
            @(negedge sclk);
            tests++;
            if (bus.rd_en !== 1'b0 || bus.done !== 1'b0 || bus.busy !== 1'b0) begin
                fails++;
                $display("FAIL busy_start tail %0d: got rd_en/done/busy=%b%b%b want 000",
                         i, bus.rd_en, bus.done, bus.busy);
            end
        end
    endtask

    task automatic test_start_held();
        @(negedge sclk);
        bus.start = 1'b1;
        check_frame("held_f1", -1, -1, -1);
        // Second frame's FETCH is two cycles after done
        check_frame("held_f2", 1, -1, -1);
    endtask

    task automatic test_reset_mid_bit();
        @(negedge sclk);
        bus.start = 1'b1;
        // t=62: byte 1, offset 19 -> data bit 3
        check_frame("mid_reset", 1, -1, 62);
        for (int i = 0; i < 5; i++) begin
            @(negedge sclk);
            tests++;
            if ({bus.tx, bus.busy, bus.rd_en, bus.done} !== 4'b1000) begin
                fails++;
                $display("FAIL mid_reset hold %0d: got tx/busy/rd_en/done=%b%b%b%b want 1000",
                         i, bus.tx, bus.busy, bus.rd_en, bus.done);
            end
        end
        rst_n = 1'b1;
        @(negedge sclk);
        bus.start = 1'b1;
        check_frame("after_reset", 1, -1, -1);
    endtask

    initial begin
        tests = 0;
        fails = 0;
        exp_bytes[0] = 8'h55;
        exp_bytes[1] = 8'hA3;
        exp_bytes[2] = 8'h00;
        exp_bytes[3] = 8'hFF;
        for (int i = 0; i < PIX_NUM; i++) ram[i] = exp_bytes[i];
        bus.start   = 1'b0;
        bus.rd_data = 8'h00;
        rst_n       = 1'b0;

        test_reset();
        test_idle_line();
        test_single_start();
        test_start_while_busy();
        test_start_held();
        test_reset_mid_bit();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/frame_readback_tx.md
# frame_readback_tx

Frame readback transmitter for the Sobel edge-detection system. Reads a stored frame from the pixel frame-buffer RAM and sends it byte-by-byte over UART 8N1 to the host. It is the other direction of the pixel write path, where UART-received bytes with `pi_flag` strobes are written into RAM. Runs entirely in the system clock domain and uses the RAM's second synchronous read port.

## Interface
Parameters:
- `PIX_NUM`, default 10000: pixels per frame (100×100), bytes sent per frame.
- `ADDR_W`, default 14: RAM address width; must satisfy 2^ADDR_W ≥ PIX_NUM.
- `BAUD_DIV`, default 5208: `sclk` cycles per UART bit (50 MHz / 9600); minimum 2.

Ports:
- `sclk`, in, 1: system clock, 50 MHz. This is the only clock.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `start`, in, 1: level/pulse request to send one frame; sampled only in IDLE.
- `rd_en`, out, 1: RAM read enable.
- `rd_addr`, out, ADDR_W: RAM read address.
- `rd_data`, in, 8: RAM read data, valid the cycle after the `rd_en` cycle.
- `tx`, out, 1: UART serial output, idle high.
- `busy`, out, 1: high from the first FETCH cycle until DONE completes.
- `done`, out, 1: one-cycle pulse when the last stop bit finishes.

## Operation
Internal state:
- `pix_cnt`: pixel counter, width ADDR_W, range 0..PIX_NUM-1.
- `baud_cnt`: bit-timing counter, range 0..BAUD_DIV-1.
- `bit_cnt`: bit index, range 0..9.
- `shift`: 10-bit shift register holding {stop=1, data[7:0], start=0}, sent LSB first.

FSM states:
- **IDLE**: `tx`=1, `busy`=0, `pix_cnt`=0. If `start`=1, go to FETCH.
- **FETCH** (1 cycle): `rd_en`=1, `rd_addr`=`pix_cnt`. Go to WAIT.
- **WAIT** (1 cycle): `rd_en`=0. At the end of this cycle, load `shift` ← {1'b1, `rd_data`, 1'b0}, clear `baud_cnt` and `bit_cnt`. Go to SEND.
- **SEND**: `tx`=`shift[0]`.
  - When `baud_cnt`=BAUD_DIV-1: `baud_cnt` wraps to 0, `shift` shifts right, `bit_cnt` increments.
  - On the wrap with `bit_cnt`=9 (end of the stop bit): if `pix_cnt`=PIX_NUM-1, go to DONE; otherwise increment `pix_cnt` and go to FETCH.
- **DONE** (1 cycle): `done`=1, `busy`=1, `tx`=1. Go to IDLE.

Additional rules:
- `tx` is 1 in every state except SEND, so gaps between bytes are idle-high.
- `start` asserted outside IDLE is ignored and is not queued. If `start` is held high through DONE, a new frame begins immediately after IDLE.
- `rd_addr` holds its last value outside FETCH. It is only meaningful while `rd_en`=1.
- `pix_cnt` never exceeds PIX_NUM-1, so no address wrap occurs.
- Asserting `rst_n`=0 in any state, including mid-bit, immediately forces the reset values below. The partial byte is abandoned and no `done` is issued.

## Timing
- Reset values: `tx`=1, `busy`=0, `done`=0, `rd_en`=0, `rd_addr`=0. State=IDLE, all counters 0.
- All outputs are registered or decoded from registered state, with no combinational path from inputs.
- With `start` sampled high at rising edge k:
  - FETCH occupies cycle k+1, with `busy` rising at k+1.
  - WAIT occupies cycle k+2.
  - The start bit drives `tx` low from cycle k+3 for BAUD_DIV cycles.
- Each byte takes 2 + 10·BAUD_DIV cycles, from FETCH through the end of the stop bit.
- A frame takes PIX_NUM·(2+10·BAUD_DIV) cycles. `done` is high in the cycle immediately after the last stop bit. `busy` falls the cycle after `done`.
- RAM contract: synchronous read with exactly 1-cycle latency. `rd_data` is sampled only at the end of WAIT.

## Test plan
Bench uses BAUD_DIV=4, PIX_NUM=4, and a RAM model preloaded with 0x55, 0xA3, 0x00, 0xFF.
- **Reset and single start:** hold reset, then pulse `start` for 1 cycle.
  - Required: `rd_en` high for 1 cycle at addresses 0, 1, 2, 3 in turn.
  - Required: serial decode yields 0x55, 0xA3, 0x00, 0xFF.
  - Required: each bit lasts exactly 4 cycles, with a 2-cycle idle-high gap between bytes.
- **Latency and frame length:** `start` at edge k.
  - Required: `tx` falls at k+3.
  - Required: `done` pulses exactly 4·42=168 cycles after k+1, then `busy`=0 the following cycle.
- **Start while busy:** pulse `start` during the second byte.
  - Required: no restart, addresses stay 0..3 once, and exactly one `done`.
- **Start held high:** keep `start`=1 continuously.
  - Required: back-to-back frames, with the next FETCH (addr 0) on the cycle after IDLE, i.e. 2 cycles after `done`.
- **Reset mid-bit:** drop `rst_n` during data bit 3 of byte 1.
  - Required: `tx`=1, `busy`=0, `rd_en`=0 immediately, with no `done`.
  - Required: a subsequent `start` resends from address 0.
- **Idle line:** with no `start` for 1000 cycles after reset.
  - Required: `tx`=1, `rd_en`=0, `busy`=0 throughout.
